ics1_replay: RTL and testbench

//  Parametrised successor to the ICS1 restart stage. Tracks up to DEPTH read addresses in flight

---
 rtl/ics1_replay.sv | 139 +++++++++++++
 tb/tb_ics1_replay.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ics1_replay.sv
// ICS1 restart stage: tracks in-flight read addresses and, after a miss resolves,
// re-issues the squashed ones oldest first before resuming pass-through.
module ics1_replay #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         i_halt,
    input  logic                         i_flush,
    input  logic [ADDR_WIDTH-1:0]        i_curr_r_addr,
    input  logic                         i_curr_r_addr_valid,
    output logic                         o_curr_r_addr_ready,
    input  logic                         i_miss_state,
    input  logic                         i_retire,
    output logic [ADDR_WIDTH-1:0]        o_r_addr,
    output logic                         o_r_addr_valid,
    output logic                         o_replaying,
    output logic [$clog2(DEPTH+1)-1:0]   o_inflight_cnt,
    output logic [1:0]                   dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: an address is issued in any cycle where o_r_addr_valid=1 and
    // i_halt=0; the consumer never stalls. Upstream is accepted when ready and
    // valid are both high, which is exactly an IDLE-state issue.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        REPLAY    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, rp_q, rp_d, rd_idx;
    logic [CW-1:0]         cnt_q, cnt_d, rp_new, cnt_new;
    logic                  push, pop, issue, full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid, ready;

    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_idx = head_q + rp_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        pop     = 1'b0;
        issue   = 1'b0;
        r_addr  = '0;
        r_valid = 1'b0;
        ready   = 1'b0;
        rp_new  = '0;
        cnt_new = '0;
        if (srst) begin
            state_d = IDLE;
        end else if (i_flush && !i_halt) begin
            state_d = IDLE;
            cnt_d   = '0;
            head_d  = tail_q;
            rp_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pop = i_retire && (cnt_q != '0);
                    if (i_miss_state) begin
                        state_d = MISS_WAIT;
                    end else begin
                        r_addr  = i_curr_r_addr;
                        r_valid = i_curr_r_addr_valid && !full;
                        ready   = !full && !i_halt;
                        push    = r_valid && !i_halt;
                    end
                end
                MISS_WAIT: begin
                    if (!i_miss_state) begin
                        state_d = (cnt_q != '0) ? REPLAY : IDLE;
                        rp_d    = '0;
                    end
                end
                REPLAY: begin
                    // Only entries already re-issued (below rp) may retire.
                    pop = i_retire && (rp_q != '0);
                    if (i_miss_state) begin
                        state_d = MISS_WAIT;
                        rp_d    = '0;
                    end else begin
                        r_addr  = mem_q[rd_idx];
                        r_valid = 1'b1;
                        issue   = !i_halt;
                        rp_new  = CW'(rp_q) + CW'(issue) - CW'(pop);
                        cnt_new = cnt_q - CW'(pop);
                        if (issue && (rp_new == cnt_new)) begin
                            state_d = IDLE;
                            rp_d    = '0;
                        end else begin
                            rp_d = rp_new[PW-1:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else if (!i_halt) begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= i_curr_r_addr;
    end

    assign o_r_addr            = r_addr;
    assign o_r_addr_valid      = r_valid;
    assign o_curr_r_addr_ready = ready;
    assign o_replaying         = (state_q == REPLAY) && !srst;
    assign o_inflight_cnt      = cnt_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_ics1_replay.sv
// Bench for ics1_replay: directed scenarios plus random traffic, checked against a
// queue-based reference model through a scoreboard and a negedge monitor.
module tb_ics1_replay;
    localparam int AW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          srst = 1'b1, i_halt = 1'b0, i_flush = 1'b0;
    logic [AW-1:0] i_curr_r_addr = '0;
    logic          i_curr_r_addr_valid = 1'b0, i_miss_state = 1'b0, i_retire = 1'b0;
    logic          o_curr_r_addr_ready, o_r_addr_valid, o_replaying;
    logic [AW-1:0] o_r_addr;
    logic [CW-1:0] o_inflight_cnt;
    logic [1:0]    dbg_state;

    ics1_replay #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .srst(srst), .i_halt(i_halt), .i_flush(i_flush),
        .i_curr_r_addr(i_curr_r_addr), .i_curr_r_addr_valid(i_curr_r_addr_valid),
        .o_curr_r_addr_ready(o_curr_r_addr_ready), .i_miss_state(i_miss_state),
        .i_retire(i_retire), .o_r_addr(o_r_addr), .o_r_addr_valid(o_r_addr_valid),
        .o_replaying(o_replaying), .o_inflight_cnt(o_inflight_cnt), .dbg_state(dbg_state)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    // Scoreboard state
    typedef struct {
        logic          valid;
        logic [AW-1:0] addr;
        logic          ready;
        logic          rep;
        logic [CW-1:0] cnt;
    } stat_t;
    logic [AW-1:0] exp_q[$];
    stat_t         status_q[$];
    int            tests = 0;
    int            fails = 0;

    // Reference model: in-flight addresses oldest first, plus the miss/replay progress
    logic [AW-1:0] inflight[$];
    bit            waiting   = 1'b0;
    bit            replaying = 1'b0;
    int            replayed  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, predict outputs, advance the model.
    task automatic step(input bit rst, input bit h, input bit f, input logic [AW-1:0] a,
                        input bit cv, input bit m, input bit r);
        stat_t s;
        bit    issue;
        @(posedge clk);
        #1;
        srst = rst; i_halt = h; i_flush = f; i_curr_r_addr = a;
        i_curr_r_addr_valid = cv; i_miss_state = m; i_retire = r;
        s.valid = 1'b0; s.addr = '0; s.ready = 1'b0;
        s.rep = replaying && !rst;
        s.cnt = CW'(inflight.size());
        if (rst) begin
            s.rep = 1'b0;
            inflight.delete(); waiting = 0; replaying = 0; replayed = 0;
        end else if (f && !h) begin
            inflight.delete(); waiting = 0; replaying = 0; replayed = 0;
        end else if (waiting) begin
            if (!m && !h) begin
                waiting   = 0;
                replaying = (inflight.size() > 0);
                replayed  = 0;
            end
        end else if (replaying) begin
            if (m) begin
                if (!h) begin
                    if (r && replayed > 0) void'(inflight.pop_front());
                    replaying = 0; waiting = 1; replayed = 0;
                end
            end else begin
                s.valid = 1'b1;
                s.addr  = inflight[replayed];
                if (!h) begin
                    if (r && replayed > 0) begin
                        void'(inflight.pop_front());
                        replayed--;
                    end
                    replayed++;
                    if (replayed == inflight.size()) begin
                        replaying = 0; replayed = 0;
                    end
                end
            end
        end else begin
            if (m) begin
                if (!h) begin
                    if (r && inflight.size() > 0) void'(inflight.pop_front());
                    waiting = 1;
                end
            end else begin
                s.valid = cv && (inflight.size() < DEPTH);
                s.addr  = a;
                s.ready = (inflight.size() < DEPTH) && !h;
                if (!h) begin
                    if (r && inflight.size() > 0) void'(inflight.pop_front());
                    if (s.valid) inflight.push_back(a);
                end
            end
        end
        issue = s.valid && !h && !rst;
        if (issue) exp_q.push_back(s.addr);
        status_q.push_back(s);
    endtask

    // Monitor: per-cycle status plus in-order issued-address scoreboard
    always @(negedge clk) begin
        stat_t s;
        if (status_q.size() > 0) begin
            s = status_q.pop_front();
            check("valid", 32'(o_r_addr_valid), 32'(s.valid));
            check("ready", 32'(o_curr_r_addr_ready), 32'(s.ready));
            check("replaying", 32'(o_replaying), 32'(s.rep));
            check("cnt", 32'(o_inflight_cnt), 32'(s.cnt));
            if (srst) check("addr_in_reset", 32'(o_r_addr), 32'd0);
            if (o_r_addr_valid && !i_halt && !srst) begin
                if (exp_q.size() == 0) check("unexpected_issue", 32'(o_r_addr), 32'hFFFF_FFFF);
                else check("issue_addr", 32'(o_r_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bit m_lvl;
        // Reset held 3 cycles with an upstream address pending
        @(posedge clk);
        repeat (3) step(1, 0, 0, 16'h0010, 1, 0, 0);
        step(0, 0, 0, 16'h0010, 1, 0, 0);
        step(0, 0, 0, 16'h0014, 1, 0, 0);
        // Full buffer, then retire, then push+retire together
        step(0, 0, 0, 16'h0018, 1, 0, 0);
        step(0, 0, 0, 16'h0018, 1, 0, 1);
        step(0, 0, 0, 16'h0018, 1, 0, 1);
        step(0, 0, 1, 16'h0000, 0, 0, 0);
        // Miss for 4 cycles with two entries, then full replay and pass-through
        step(0, 0, 0, 16'h0010, 1, 0, 0);
        step(0, 0, 0, 16'h0014, 1, 0, 0);
        repeat (4) step(0, 0, 0, 16'h0000, 0, 1, 0);
        repeat (3) step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0020, 1, 0, 1);
        step(0, 0, 0, 16'h0000, 0, 0, 1);
        step(0, 0, 1, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0010, 1, 0, 0);
        step(0, 0, 0, 16'h0014, 1, 0, 0);
        // Miss re-asserted mid-replay restarts from the head
        step(0, 0, 0, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        repeat (2) step(0, 0, 0, 16'h0000, 0, 0, 0);
        // Halt during replay holds the second entry on the port
        step(0, 0, 0, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        repeat (3) step(0, 1, 0, 16'h0030, 1, 0, 1);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        // Flush in MISS_WAIT, then reset mid-replay
        step(0, 0, 0, 16'h0000, 0, 1, 0);
        step(0, 0, 1, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0040, 1, 0, 0);
        step(0, 0, 0, 16'h0044, 1, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0050, 1, 0, 0);
        // Random traffic
        m_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) m_lvl = ~m_lvl;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0, AW'($urandom()),
                 $urandom_range(0, 3) != 0, m_lvl, $urandom_range(0, 2) == 0);
        end
        step(0, 0, 1, 16'h0000, 0, 0, 0);
        step(0, 0, 0, 16'h0000, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        check("leftover_status", 32'(status_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
